cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the Jac1-8 core. It fetches each 16-bit instruction from program memory into an instruction register and presents it to `decoder`. It then sequences decode, execute and writeback. During writeback it gates the decoder's raw write enables into single-cycle strobes for the register file, status register and program counter. It also owns the PC, handles run/single-step/halt control and counts retired instructions.

---
 rtl/jac_pkg.sv | 34 +++
 rtl/cpu_sequencer_pc_next.sv | 22 ++
 rtl/cpu_sequencer.sv | 105 ++++++++++
 tb/tb_cpu_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jac_pkg.sv
// Shared definitions for the Jac1-8 core: opcodes, status bits, sequencer
// state encoding and writeback source selects.
package jac_pkg;

  // Opcode field values (instruction[15:11])
  localparam logic [4:0] Op_NOP   = 5'b0_0000;
  localparam logic [4:0] Op_ADD   = 5'b0_0001;
  localparam logic [4:0] Op_SUB   = 5'b0_0010;
  localparam logic [4:0] Op_AND   = 5'b0_0011;
  localparam logic [4:0] Op_OR    = 5'b0_0100;
  localparam logic [4:0] Op_GOTO  = 5'b0_1000;
  localparam logic [4:0] Op_IFZ   = 5'b0_1010;
  localparam logic [4:0] Op_RES16 = 5'b1_1111;
  // HALT reuses the last reserved slot
  localparam logic [4:0] Op_HALT  = Op_RES16;

  // Status register bit indices
  localparam int STAT_Z = 0;
  localparam int STAT_C = 1;
  localparam int STAT_N = 2;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_HALTED    = 3'd5;

  // Register-file write data source
  localparam logic SEL_ALU     = 1'b0;
  localparam logic SEL_DECODER = 1'b1;

endpackage

// File: rtl/cpu_sequencer_pc_next.sv
// Next-PC selection: sequential +1, absolute jump, or PC-relative jump.
// All arithmetic wraps at 2^WIDTH.
module pc_next #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] literal_adr,
  input  logic             jump,
  input  logic             relative,
  output logic [WIDTH-1:0] next_pc
);

  // Pick the successor address for the instruction in writeback
  always_comb begin
    // NOTE: default assignment first so no path leaves next_pc unassigned (no latch).
    next_pc = pc + WIDTH'(1);
    if (jump) begin
      next_pc = relative ? (pc + literal_adr) : literal_adr;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the Jac1-8 core: fetches into the instruction
// register, steps through decode/execute/writeback, gates write strobes in
// writeback, owns the PC and counts retired instructions.
module cpu_sequencer
  import jac_pkg::*;
#(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumOpCodeBits     = 5,
  parameter int CountWidth        = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         step,
  output logic                         imem_req,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic [PROGRAM_DataWidth-1:0] imem_rdata,
  input  logic                         imem_valid,
  output logic [PROGRAM_DataWidth-1:0] instruction,
  input  logic                         dec_wr_en,
  input  logic                         dec_stat_wr_en,
  input  logic                         dec_cnt_wr_en,
  input  logic                         dec_add_offset,
  input  logic [PC_WIDTH-1:0]          literal_adr,
  output logic                         rf_wr_en,
  output logic                         stat_wr_en,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         busy,
  output logic                         halted,
  output logic [CountWidth-1:0]        instr_count
);

  logic [2:0]               state;
  logic                     step_flag;
  logic [PC_WIDTH-1:0]      pc_succ;
  logic [NumOpCodeBits-1:0] opcode;
  logic                     is_halt;
  logic                     wb_commit;

  assign opcode  = instruction[PROGRAM_DataWidth-1 -: NumOpCodeBits];
  assign is_halt = (opcode == NumOpCodeBits'(Op_HALT));

  // Strobes are suppressed for HALT and in a cycle where reset is pending
  assign wb_commit  = (state == ST_WRITEBACK) && !reset && !is_halt;
  assign rf_wr_en   = wb_commit && dec_wr_en;
  assign stat_wr_en = wb_commit && dec_stat_wr_en;

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign busy      = (state != ST_IDLE) && (state != ST_HALTED);
  assign halted    = (state == ST_HALTED);

  pc_next #(
    .WIDTH(PC_WIDTH)
  ) u_pc_next (
    .pc         (pc),
    .literal_adr(literal_adr),
    .jump       (dec_cnt_wr_en),
    .relative   (dec_add_offset),
    .next_pc    (pc_succ)
  );

  // Sequencer state, instruction register, PC and retire counter
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= ST_IDLE;
      step_flag   <= 1'b0;
      pc          <= '0;
      instruction <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run || step) begin
            state     <= ST_FETCH;
            step_flag <= step && !run;
          end
        end
        ST_FETCH: begin
          if (imem_valid) begin
            instruction <= imem_rdata;
            state       <= ST_DECODE;
          end
        end
        ST_DECODE:  state <= ST_EXECUTE;
        ST_EXECUTE: state <= ST_WRITEBACK;
        ST_WRITEBACK: begin
          instr_count <= instr_count + CountWidth'(1);
          step_flag   <= 1'b0;
          if (is_halt) begin
            state <= ST_HALTED;
          end else begin
            pc    <= pc_succ;
            state <= (run && !step_flag) ? ST_FETCH : ST_IDLE;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer. The bench plays the role of
// program memory and decoder, driving raw decoder outputs per instruction.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, step;
  logic        imem_req, imem_valid;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata, instruction;
  logic        dec_wr_en, dec_stat_wr_en, dec_cnt_wr_en, dec_add_offset;
  logic [7:0]  literal_adr;
  logic        rf_wr_en, stat_wr_en, busy, halted;
  logic [7:0]  pc;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Results of the most recent exec_one call
  int         r_lat, r_rf, r_st, r_req;
  logic       r_addr_ok;
  logic [7:0] r_addr;

  localparam logic [15:0] W_ADD  = {5'b0_0001, 11'h123};
  localparam logic [15:0] W_GOTO = {5'b0_1000, 11'h000};
  localparam logic [15:0] W_IFZ  = {5'b0_1010, 11'h005};
  localparam logic [15:0] W_HALT = {5'b1_1111, 11'h000};

  cpu_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .step          (step),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .instruction   (instruction),
    .dec_wr_en     (dec_wr_en),
    .dec_stat_wr_en(dec_stat_wr_en),
    .dec_cnt_wr_en (dec_cnt_wr_en),
    .dec_add_offset(dec_add_offset),
    .literal_adr   (literal_adr),
    .rf_wr_en      (rf_wr_en),
    .stat_wr_en    (stat_wr_en),
    .pc            (pc),
    .busy          (busy),
    .halted        (halted),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  // Serve one instruction from the current negedge until instr_count moves.
  task automatic exec_one(input logic [15:0] word, input logic wr, input logic st,
                          input logic cnt, input logic add, input logic [7:0] lit,
                          input int waits, input logic [7:0] step_mask);
    logic [15:0] start;
    int   w;
    logic seen, done;
    start = instr_count; w = waits; seen = 0; done = 0;
    r_lat = 0; r_rf = 0; r_st = 0; r_req = 0; r_addr_ok = 1; r_addr = '0;
    dec_wr_en = wr; dec_stat_wr_en = st; dec_cnt_wr_en = cnt;
    dec_add_offset = add; literal_adr = lit;
    for (int i = 0; i < 60; i++) begin
      step = (i < 8) ? step_mask[i] : 1'b0;
      if (instr_count != start) begin
        done = 1;
        break;
      end
      if (imem_req) begin
        if (!seen) begin
          r_addr = imem_addr;
          seen   = 1;
        end else if (imem_addr != r_addr) begin
          r_addr_ok = 0;
        end
        r_req++;
        if (w > 0) begin
          imem_valid = 0; imem_rdata = 16'hDEAD; w--;
        end else begin
          imem_valid = 1; imem_rdata = word;
        end
      end else begin
        imem_valid = 0; imem_rdata = 16'hDEAD;
      end
      #1;
      if (rf_wr_en)   r_rf++;
      if (stat_wr_en) r_st++;
      if (busy)       r_lat++;
      @(negedge clk);
    end
    step = 0; imem_valid = 0;
    n_checks++;
    if (!done) $display("FAIL retire_timeout: instr_count stayed %0d, required %0d", instr_count, start + 16'd1);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1; run = 0; step = 0; imem_valid = 0; imem_rdata = '0;
    dec_wr_en = 1; dec_stat_wr_en = 1; dec_cnt_wr_en = 0; dec_add_offset = 0; literal_adr = '0;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    n_checks++;
    if ({pc, instruction, instr_count} !== 40'h0 ||
        {imem_req, rf_wr_en, stat_wr_en, busy, halted} !== 5'b0)
      $display("FAIL reset_values: pc=%h ir=%h cnt=%0d req/rf/st/busy/halt=%b required all zero",
               pc, instruction, instr_count, {imem_req, rf_wr_en, stat_wr_en, busy, halted});
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_add;
    run = 1;
    exec_one(W_ADD, 1, 1, 0, 0, 8'h00, 0, 8'h00);
    n_checks++;
    if (r_lat !== 4) $display("FAIL add_latency: got %0d cycles, required 4", r_lat); else n_pass++;
    n_checks++;
    if (r_rf !== 1 || r_st !== 1) $display("FAIL add_strobes: rf=%0d stat=%0d pulses, required 1/1", r_rf, r_st); else n_pass++;
    n_checks++;
    if (pc !== 8'h01 || instr_count !== 16'd1) $display("FAIL add_pc_count: pc=%h cnt=%0d, required 01/1", pc, instr_count); else n_pass++;
    n_checks++;
    if (instruction !== W_ADD) $display("FAIL add_ir: ir=%h, required %h", instruction, W_ADD); else n_pass++;
  endtask

  task automatic test_goto;
    exec_one(W_GOTO, 0, 0, 1, 0, 8'h10, 0, 8'h00);
    n_checks++;
    if (pc !== 8'h10) $display("FAIL goto_10: pc=%h, required 10", pc); else n_pass++;
    exec_one(W_GOTO, 0, 0, 1, 0, 8'h3F, 0, 8'h00);
    n_checks++;
    if (pc !== 8'h3F || r_addr !== 8'h10) $display("FAIL goto_3f: pc=%h fetch_addr=%h, required 3F/10", pc, r_addr); else n_pass++;
    n_checks++;
    if (r_rf !== 0 || r_st !== 0) $display("FAIL goto_strobes: rf=%0d stat=%0d, required 0/0", r_rf, r_st); else n_pass++;
  endtask

  task automatic test_wrap;
    exec_one(W_GOTO, 0, 0, 1, 0, 8'hFE, 0, 8'h00);
    exec_one(W_IFZ, 0, 0, 1, 1, 8'h05, 0, 8'h00);
    n_checks++;
    if (pc !== 8'h03) $display("FAIL rel_wrap: pc=%h, required 03", pc); else n_pass++;
    exec_one(W_GOTO, 0, 0, 1, 0, 8'hFF, 0, 8'h00);
    exec_one(W_ADD, 1, 0, 0, 0, 8'h00, 0, 8'h00);
    n_checks++;
    if (pc !== 8'h00 || instr_count !== 16'd7) $display("FAIL seq_wrap: pc=%h cnt=%0d, required 00/7", pc, instr_count); else n_pass++;
  endtask

  task automatic test_wait_states;
    exec_one(W_ADD, 1, 1, 0, 0, 8'h00, 3, 8'h00);
    n_checks++;
    if (r_lat !== 7) $display("FAIL wait_latency: got %0d cycles, required 7", r_lat); else n_pass++;
    n_checks++;
    if (r_req !== 4 || !r_addr_ok || r_addr !== 8'h00)
      $display("FAIL wait_fetch: req_cycles=%0d addr_stable=%b addr=%h, required 4/1/00", r_req, r_addr_ok, r_addr);
    else n_pass++;
  endtask

  task automatic test_run_drop;
    run = 0;
    exec_one(W_ADD, 1, 1, 0, 0, 8'h00, 0, 8'h00);
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 0 || instr_count !== 16'd9 || pc !== 8'h02)
      $display("FAIL run_drop: busy=%b cnt=%0d pc=%h, required 0/9/02", busy, instr_count, pc);
    else n_pass++;
  endtask

  task automatic test_step;
    // step at IDLE, then a second pulse while busy
    exec_one(W_ADD, 1, 1, 0, 0, 8'h00, 0, 8'b0000_0101);
    n_checks++;
    if (r_lat !== 4 || r_rf !== 1) $display("FAIL step_one: lat=%0d rf=%0d, required 4/1", r_lat, r_rf); else n_pass++;
    repeat (6) @(negedge clk);
    n_checks++;
    if (busy !== 0 || instr_count !== 16'd10 || pc !== 8'h03)
      $display("FAIL step_ignored: busy=%b cnt=%0d pc=%h, required 0/10/03", busy, instr_count, pc);
    else n_pass++;
  endtask

  task automatic test_halt;
    int req_seen;
    run = 1;
    exec_one(W_HALT, 1, 1, 1, 0, 8'h55, 0, 8'h00);
    n_checks++;
    if (r_rf !== 0 || r_st !== 0) $display("FAIL halt_strobes: rf=%0d stat=%0d, required 0/0", r_rf, r_st); else n_pass++;
    n_checks++;
    if (pc !== 8'h03 || instr_count !== 16'd11 || halted !== 1 || busy !== 0)
      $display("FAIL halt_state: pc=%h cnt=%0d halted=%b busy=%b, required 03/11/1/0", pc, instr_count, halted, busy);
    else n_pass++;
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step = i[0];
      @(negedge clk);
      if (imem_req) req_seen++;
    end
    step = 0;
    n_checks++;
    if (req_seen != 0 || halted !== 1 || pc !== 8'h03 || instr_count !== 16'd11)
      $display("FAIL halt_sticky: req_cycles=%0d halted=%b pc=%h cnt=%0d, required 0/1/03/11", req_seen, halted, pc, instr_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    reset = 1; run = 0;
    @(negedge clk);
    reset = 0;
    n_checks++;
    if (halted !== 0 || pc !== 8'h00 || instr_count !== 16'd0)
      $display("FAIL halt_reset: halted=%b pc=%h cnt=%0d, required 0/00/0", halted, pc, instr_count);
    else n_pass++;
    run = 1; dec_wr_en = 1; dec_stat_wr_en = 1; dec_cnt_wr_en = 0;
    for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
    imem_valid = 1; imem_rdata = W_ADD;
    @(negedge clk);                 // DECODE
    imem_valid = 0;
    @(negedge clk);                 // EXECUTE
    reset = 1; run = 0;
    #1;
    n_checks++;
    if (rf_wr_en !== 0 || stat_wr_en !== 0) $display("FAIL exec_reset_strobe: rf=%b stat=%b, required 0/0", rf_wr_en, stat_wr_en); else n_pass++;
    @(negedge clk);
    reset = 0;
    #1;
    n_checks++;
    if ({pc, instruction, instr_count} !== 40'h0 ||
        {imem_req, rf_wr_en, stat_wr_en, busy, halted} !== 5'b0)
      $display("FAIL exec_reset_values: pc=%h ir=%h cnt=%0d req/rf/st/busy/halt=%b required all zero",
               pc, instruction, instr_count, {imem_req, rf_wr_en, stat_wr_en, busy, halted});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rf_wr_en !== 0 || busy !== 0 || instr_count !== 16'd0)
      $display("FAIL post_reset_quiet: rf=%b busy=%b cnt=%0d, required 0/0/0", rf_wr_en, busy, instr_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_goto();
    test_wrap();
    test_wait_states();
    test_run_drop();
    test_step();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
